// File: rtl/spi_slave_rx.sv
// SPI slave receiver: LSB-first frames of WIDTH bits, one per cs assertion.
// Define SPI_RX_FIFO_EN for 4-entry FIFO storage (default: one holding register).
module spi_slave_rx #(
   parameter int WIDTH = 3
) (
   input  logic             clka,
   input  logic             reset,
   input  logic             cs,
   input  logic             MOSI,
   input  logic             rx_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             cs_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] bit_w;
   logic [WIDTH-1:0] word;
   logic             push, pop, full, accept;
   logic             ovf_evt, ferr_evt;
   logic             overrun_q, overrun_d;
   logic             ferr_q, ferr_d;

   assign bit_w = {{(WIDTH-1){1'b0}}, MOSI};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      push     = 1'b0;
      ferr_evt = 1'b0;
      word     = sh_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            sh_d  = '0;
            if (cs_q) begin
               sh_d    = bit_w;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!cs_q) begin
               // partial word is discarded
               state_d  = IDLE;
               cnt_d    = '0;
               sh_d     = '0;
               ferr_evt = (cnt_q != '0);
            end else begin
               sh_d  = sh_q | (bit_w << cnt_q);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  push    = 1'b1;
                  word    = sh_d;
               end
            end
         end
         DONE: begin
            if (!cs_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               sh_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q <= IDLE;
         cs_q    <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
      end
   end

   assign busy    = (state_q == SHIFT);
   assign pop     = rx_valid & rx_ready;
   assign accept  = push & (~full | pop);
   assign ovf_evt = push & full & ~pop;

`ifdef SPI_RX_FIFO_EN
   logic [WIDTH-1:0] mem_q [4];
   logic [1:0]       wp_q, rp_q;
   logic [2:0]       n_q;

   assign full     = (n_q == 3'd4);
   assign rx_valid = (n_q != 3'd0);
   assign rx_data  = mem_q[rp_q];

   always_ff @(posedge clka) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wp_q <= '0;
         rp_q <= '0;
         n_q  <= '0;
      end else begin
         if (pop) rp_q <= rp_q + 2'd1;
         if (accept) begin
            mem_q[wp_q] <= word;
            wp_q        <= wp_q + 2'd1;
         end
         unique case ({accept, pop})
            2'b10:   n_q <= n_q + 3'd1;
            2'b01:   n_q <= n_q - 3'd1;
            default: n_q <= n_q;
         endcase
      end
   end
`else
   logic [WIDTH-1:0] hold_q;
   logic             valid_q;

   assign full     = valid_q;
   assign rx_valid = valid_q;
   assign rx_data  = hold_q;

   always_ff @(posedge clka) begin
      if (reset) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else if (accept) begin
         hold_q  <= word;
         valid_q <= 1'b1;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end
`endif

   // an error event in the clearing cycle wins over clr_err
   assign overrun_d = (overrun_q & ~clr_err) | ovf_evt;
   assign ferr_d    = (ferr_q & ~clr_err) | ferr_evt;

   always_ff @(posedge clka) begin
      if (reset) begin
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign overrun   = overrun_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx (WIDTH=3), either storage build.
module tb_spi_slave_rx;

   localparam int W = 3;
`ifdef SPI_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic         clka;
   logic         reset;
   logic         cs;
   logic         MOSI;
   logic         rx_ready;
   logic         clr_err;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;
   logic         overrun;
   logic         frame_err;

   int total;
   int passed;
   int nvalid;
   int nbusy;
   logic         v_log [16];
   logic [W-1:0] d_log [16];
   logic         b_log [16];

   spi_slave_rx #(.WIDTH(W)) dut (
      .clka      (clka),
      .reset     (reset),
      .cs        (cs),
      .MOSI      (MOSI),
      .rx_ready  (rx_ready),
      .clr_err   (clr_err),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic clk1();
      @(posedge clka);
      #1;
   endtask

   // Cycle i drives the inputs seen at edge E_i; data bit k is sampled at E_(k+1).
   task automatic run_frame(input logic [W-1:0] d, input int ncs,
                            input int ncyc, input logic [31:0] rdy_mask,
                            input int clr_at);
      nvalid = 0;
      nbusy  = 0;
      for (int i = 0; i < ncyc; i++) begin
         cs       = (i < ncs);
         MOSI     = (i >= 1 && i <= W) ? d[i-1] : 1'b1;
         rx_ready = rdy_mask[i];
         clr_err  = (i == clr_at);
         clk1();
         v_log[i] = rx_valid;
         d_log[i] = rx_data;
         b_log[i] = busy;
         nvalid  += int'(rx_valid);
         nbusy   += int'(busy);
      end
      cs       = 1'b0;
      MOSI     = 1'b0;
      rx_ready = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cs = 1'b0; MOSI = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
      clk1();
      clk1();
      reset = 1'b0;
      clk1();
      total++;
      if ({rx_valid, busy, overrun, frame_err} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000",
                  {rx_valid, busy, overrun, frame_err});
      else passed++;
      total++;
      if (rx_data !== 3'b000)
         $display("FAIL reset_data got %b want 000", rx_data);
      else passed++;
   endtask

   task automatic test_single();
      run_frame(3'b101, 5, 8, 32'hFFFF_FFFF, -1);
      total++;
      if (nvalid != 1 || v_log[3] !== 1'b1)
         $display("FAIL single_valid got n=%0d v3=%b want n=1 v3=1", nvalid, v_log[3]);
      else passed++;
      total++;
      if (d_log[3] !== 3'b101)
         $display("FAIL single_data got %b want 101", d_log[3]);
      else passed++;
      total++;
      if ({b_log[0], b_log[1], b_log[2], b_log[3]} !== 4'b0110)
         $display("FAIL single_busy got %b want 0110",
                  {b_log[0], b_log[1], b_log[2], b_log[3]});
      else passed++;
      total++;
      if ({overrun, frame_err} !== 2'b00)
         $display("FAIL single_errs got %b want 00", {overrun, frame_err});
      else passed++;
   endtask

   task automatic test_long_cs();
      run_frame(3'b110, 10, 13, 32'hFFFF_FFFF, -1);
      total++;
      if (nvalid != 1 || d_log[3] !== 3'b110)
         $display("FAIL long_cs_push got n=%0d d=%b want n=1 d=110", nvalid, d_log[3]);
      else passed++;
      total++;
      if (nbusy != 2 || b_log[3] !== 1'b0)
         $display("FAIL long_cs_busy got n=%0d b3=%b want n=2 b3=0", nbusy, b_log[3]);
      else passed++;
      total++;
      if ({rx_valid, overrun, frame_err} !== 3'b000)
         $display("FAIL long_cs_end got %b want 000", {rx_valid, overrun, frame_err});
      else passed++;
   endtask

   task automatic test_frame_err();
      run_frame(3'b011, 2, 5, 32'h0, -1);
      total++;
      if (frame_err !== 1'b1 || nvalid != 0)
         $display("FAIL ferr_set got fe=%b n=%0d want fe=1 n=0", frame_err, nvalid);
      else passed++;
      clr_err = 1'b1;
      clk1();
      clr_err = 1'b0;
      total++;
      if (frame_err !== 1'b0)
         $display("FAIL ferr_clr got %b want 0", frame_err);
      else passed++;
      run_frame(3'b011, 2, 5, 32'h0, 3);
      total++;
      if (frame_err !== 1'b1)
         $display("FAIL ferr_clr_same_cycle got %b want 1", frame_err);
      else passed++;
      clr_err = 1'b1;
      clk1();
      clr_err = 1'b0;
      total++;
      if ({frame_err, rx_valid, busy} !== 3'b000)
         $display("FAIL ferr_clr2 got %b want 000", {frame_err, rx_valid, busy});
      else passed++;
   endtask

   task automatic test_overrun();
      for (int k = 1; k <= DEPTH + 1; k++) begin
         run_frame(3'(k), 3, 4, 32'h0, -1);
         total++;
         if (overrun !== (k > DEPTH) || rx_data !== 3'b001)
            $display("FAIL overrun_word%0d got ov=%b d=%b want ov=%b d=001",
                     k, overrun, rx_data, (k > DEPTH));
         else passed++;
      end
      rx_ready = 1'b1;
      for (int j = 1; j <= DEPTH; j++) begin
         total++;
         if (rx_valid !== 1'b1 || rx_data !== 3'(j))
            $display("FAIL overrun_drain%0d got v=%b d=%b want v=1 d=%0d",
                     j, rx_valid, rx_data, j);
         else passed++;
         clk1();
      end
      rx_ready = 1'b0;
      total++;
      if (rx_valid !== 1'b0)
         $display("FAIL overrun_empty got %b want 0", rx_valid);
      else passed++;
      clr_err = 1'b1;
      clk1();
      clr_err = 1'b0;
      total++;
      if (overrun !== 1'b0)
         $display("FAIL overrun_clr got %b want 0", overrun);
      else passed++;
   endtask

   task automatic test_full_pop();
      logic [W-1:0] exp;
      for (int k = 1; k <= DEPTH; k++) run_frame(3'(k), 3, 4, 32'h0, -1);
      run_frame(3'b111, 3, 4, 32'h8, -1);
      total++;
      if (overrun !== 1'b0 || rx_valid !== 1'b1)
         $display("FAIL full_pop_flags got ov=%b v=%b want ov=0 v=1", overrun, rx_valid);
      else passed++;
      rx_ready = 1'b1;
      for (int j = 2; j <= DEPTH + 1; j++) begin
         exp = (j <= DEPTH) ? 3'(j) : 3'b111;
         total++;
         if (rx_valid !== 1'b1 || rx_data !== exp)
            $display("FAIL full_pop_drain%0d got v=%b d=%b want v=1 d=%b",
                     j, rx_valid, rx_data, exp);
         else passed++;
         clk1();
      end
      rx_ready = 1'b0;
      total++;
      if (rx_valid !== 1'b0)
         $display("FAIL full_pop_empty got %b want 0", rx_valid);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      for (int k = 1; k <= DEPTH + 1; k++) run_frame(3'(k), 3, 4, 32'h0, -1);
      total++;
      if (overrun !== 1'b1 || rx_valid !== 1'b1)
         $display("FAIL rst_pre got ov=%b v=%b want ov=1 v=1", overrun, rx_valid);
      else passed++;
      cs = 1'b1; MOSI = 1'b0;
      clk1();
      MOSI = 1'b1;
      clk1();
      reset = 1'b1; cs = 1'b0;
      clk1();
      total++;
      if ({rx_valid, busy, overrun, frame_err} !== 4'b0000 || rx_data !== 3'b000)
         $display("FAIL rst_mid got flags=%b d=%b want 0000 d=000",
                  {rx_valid, busy, overrun, frame_err}, rx_data);
      else passed++;
      reset = 1'b0;
      clk1();
      clk1();
      clk1();
      total++;
      if (frame_err !== 1'b0 || busy !== 1'b0)
         $display("FAIL rst_mid_after got fe=%b b=%b want 0 0", frame_err, busy);
      else passed++;
      reset = 1'b1; cs = 1'b1;
      clk1();
      reset = 1'b0;
      run_frame(3'b011, 3, 7, 32'hFFFF_FFFF, -1);
      total++;
      if (nvalid != 1 || v_log[3] !== 1'b1 || d_log[3] !== 3'b011)
         $display("FAIL rst_cs_high got n=%0d v3=%b d=%b want n=1 v3=1 d=011",
                  nvalid, v_log[3], d_log[3]);
      else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_single();
      test_long_cs();
      test_frame_err();
      test_overrun();
      test_full_pop();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter: WIDTH, 3, bits per frame; legal range 2..8.
REQ-002 clka  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cs  input  1  frame-active; driven from the same send level that drives the serial transmitter.
REQ-005 MOSI  input  1  serial data from the transmitter, LSB first, one bit per clka cycle.
REQ-006 rx_ready  input  1  consumer accepts the head word when rx_ready and rx_valid are both high.
REQ-007 clr_err  input  1  clears the sticky error flags.
REQ-008 rx_data  output  WIDTH  head word of storage; meaningful only while rx_valid is high.
REQ-009 rx_valid  output  1  storage non-empty.
REQ-010 busy  output  1  frame reception in progress.
REQ-011 overrun  output  1  sticky; a completed word was dropped because storage was full.
REQ-012 frame_err  output  1  sticky; cs fell before WIDTH bits were received.

Function
REQ-013 The block SHALL register cs into cs_q every cycle and sample MOSI only at edges where cs_q=1 and bit count < WIDTH.
- Consequence: first edge with cs=1 is E0; data[0..WIDTH-1] are sampled at E1..E_WIDTH.
REQ-014 The block SHALL shift each sampled bit into position count of the shift register (LSB first) and increment count.
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE.
- IDLE->SHIFT when cs_q=1.
- SHIFT->DONE at the edge sampling bit WIDTH-1.
- DONE->IDLE when cs_q=0.
- SHIFT->IDLE when cs_q=0.
REQ-016 At the SHIFT->DONE edge the block SHALL push the assembled word into storage, so rx_valid rises in the cycle after E_WIDTH.
REQ-017 In DONE the block SHALL ignore MOSI; one word is received per cs assertion.
REQ-018 If cs_q falls in SHIFT with count > 0, the block SHALL discard the partial word, set frame_err and return to IDLE.
- If count = 0 at that point, no error is flagged.
REQ-019 busy SHALL be high in SHIFT and low otherwise.
REQ-020 A pop SHALL occur at each edge where rx_valid=1 and rx_ready=1, and SHALL advance the head.
REQ-021 If a push and a pop coincide, the pop SHALL be applied first, so a full storage accepts the new word without overrun.
REQ-022 A push while storage is full and no pop occurs SHALL drop the new word, set overrun and leave the stored contents unchanged.
REQ-023 clr_err=1 SHALL clear overrun and frame_err at that edge.
- If an error event occurs in the same cycle as clr_err, the flag SHALL remain set.
REQ-024 rx_data SHALL be stable while rx_valid=1 and rx_ready=0.

Reset
REQ-025 On reset=1 at an edge, the block SHALL enter IDLE and clear count, cs_q, the shift register, storage, rx_valid, busy, overrun and frame_err.
- After reset, rx_data reads 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without setting frame_err.
- A frame starting when reset releases with cs already high SHALL be received normally from the next edge.

Configuration
REQ-027 When SPI_RX_FIFO_EN is defined, storage SHALL be a 4-entry circular FIFO.
- Full = 4 words held.
- Read and write pointers wrap modulo 4.
REQ-028 When SPI_RX_FIFO_EN is undefined, storage SHALL be a single holding register.
- Full = rx_valid high.
- Ports and all other behaviour are identical in both builds.

Verification
REQ-029 Bench SHALL cover: reset, then cs=1 for 5 cycles, MOSI per transmitter of data=3'b101, rx_ready=1 -> rx_data=3'b101, rx_valid high for exactly 1 cycle starting the cycle after E3; no error flags.
REQ-030 Bench SHALL cover: cs held high for 10 cycles after word 3'b110 -> exactly one push; bits after E3 are ignored; busy low after E3.
REQ-031 Bench SHALL cover: cs dropped after 2 bits -> frame_err=1 and no push; clr_err pulse -> frame_err=0.
REQ-032 Bench SHALL cover: rx_ready=0 with frames 3'b001, 3'b010, ... sent back-to-back -> overrun set on word 2 (FIFO undefined) or word 5 (FIFO defined), and stored words are unchanged and in order.
REQ-033 Bench SHALL cover: storage full and rx_ready=1 in the same cycle as a push -> no overrun, and the new word is delivered after the old ones.
REQ-034 Bench SHALL cover: reset pulsed at E2 of a frame -> all outputs 0 next cycle, and frame_err stays 0.
